// File: rtl/sine_lut_sqrt_if.sv
// Data bus of the sine/sqrt primitive: phase and radicand in, sine sample and root out.
// The slave side is the DSP block and the master side is whoever feeds it.
interface sine_lut_sqrt_if;
    logic        [11:0] DAT_i;
    logic signed [11:0] SIN_o;
    logic        [22:0] DATs_i;
    logic        [11:0] QQs_o;

    modport slave  (input  DAT_i, DATs_i, output SIN_o, QQs_o);
    modport master (output DAT_i, DATs_i, input  SIN_o, QQs_o);
endinterface

// File: rtl/sine_lut_sqrt.sv
// Quadrature LO sine lookup (1-cycle latency) and 12-stage pipelined integer square root.
// The two units are independent and share only the clock and the asynchronous reset.
module sine_lut_sqrt (
    input  logic             CK_i,
    input  logic             XARST_i,
    sine_lut_sqrt_if.slave   bus
);

    typedef logic [127:0] u128_t;

    localparam u128_t SCALE = 128'd1000000000000000000;
    localparam u128_t PI_S  = 128'd3141592653589793238;

    // Quarter-wave entry round(2047*sin(2*pi*idx/4096)), evaluated at elaboration
    // with an integer Taylor series in 1e-18 fixed point so no real math reaches hardware.
    function automatic logic [10:0] qsin(input int unsigned idx);
        u128_t x;
        u128_t t;
        u128_t sp;
        u128_t sn;
        x  = (PI_S * u128_t'(idx)) / u128_t'(2048);
        t  = x;
        sp = x;
        sn = '0;
        for (int k = 1; k <= 11; k++) begin
            t = (t * x) / SCALE;
            t = (t * x) / SCALE;
            t = t / u128_t'((2 * k) * (2 * k + 1));
            if (k % 2 == 1) sn = sn + t;
            else            sp = sp + t;
        end
        return 11'(((sp - sn) * u128_t'(2047) + SCALE / u128_t'(2)) / SCALE);
    endfunction

    logic [10:0] rom [1024];

    for (genvar g = 0; g < 1024; g++) begin : g_rom
        localparam logic [10:0] V = qsin(g);
        assign rom[g] = V;
    end

    logic        [9:0]  lo;
    logic        [9:0]  lo_mir;
    logic        [10:0] mag;
    logic signed [11:0] sin_d;
    logic signed [11:0] sin_q;

    // Quadrant fold: odd quadrants read the table mirrored, the lower half-turn is negated.
    always_comb begin
        lo     = bus.DAT_i[9:0];
        lo_mir = 10'd0 - lo;
        mag    = rom[lo];
        if (bus.DAT_i[10]) begin
            mag = (lo == 10'd0) ? 11'd2047 : rom[lo_mir];
        end
        sin_d = bus.DAT_i[11] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) sin_q <= '0;
        else          sin_q <= sin_d;
    end

    assign bus.SIN_o = sin_q;

    // Restoring square root: stage k consumes two radicand bits and emits one root bit.
    // The remainder never exceeds 2*root, so 13 bits hold it even for the largest radicand.
    logic [12:0] rem_in  [12];
    logic [10:0] root_in [12];
    logic [23:0] rad_in  [12];
    logic [14:0] acc     [12];
    logic [14:0] trial   [12];
    logic [12:0] rem_d   [12];
    logic [11:0] root_d  [12];
    logic [23:0] rad_d   [12];
    logic [12:0] rem_q   [12];
    logic [11:0] root_q  [12];
    logic [23:0] rad_q   [12];

    always_comb begin
        rem_in[0]  = '0;
        root_in[0] = '0;
        rad_in[0]  = {1'b0, bus.DATs_i};
        for (int k = 1; k < 12; k++) begin
            rem_in[k]  = rem_q[k-1];
            root_in[k] = root_q[k-1][10:0];
            rad_in[k]  = rad_q[k-1];
        end
        for (int k = 0; k < 12; k++) begin
            acc[k]   = {rem_in[k], rad_in[k][23:22]};
            trial[k] = acc[k] - {2'b00, root_in[k], 2'b01};
            if (!trial[k][14]) begin
                rem_d[k]  = trial[k][12:0];
                root_d[k] = {root_in[k], 1'b1};
            end else begin
                rem_d[k]  = acc[k][12:0];
                root_d[k] = {root_in[k], 1'b0};
            end
            rad_d[k] = {rad_in[k][21:0], 2'b00};
        end
    end

    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            for (int k = 0; k < 12; k++) begin
                rem_q[k]  <= '0;
                root_q[k] <= '0;
                rad_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 12; k++) begin
                rem_q[k]  <= rem_d[k];
                root_q[k] <= root_d[k];
                rad_q[k]  <= rad_d[k];
            end
        end
    end

    assign bus.QQs_o = root_q[11];

endmodule

// File: tb/tb_sine_lut_sqrt.sv
// Scoreboard bench for sine_lut_sqrt: the driver queues expected outputs with their due edge,
// the monitor compares them as the pipelines deliver, and sine symmetries are checked at the end.
module tb_sine_lut_sqrt;

    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst_n;

    sine_lut_sqrt_if bus ();

    sine_lut_sqrt dut (
        .CK_i    (clk),
        .XARST_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        int val;
        int arg;
    } exp_t;

    exp_t sin_q[$];
    exp_t sq_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int release_edge = 0;
    int obs [4096];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Nearest integer, ties away from zero.
    function automatic int round_away(input real r);
        if (r >= 0.0) return $rtoi($floor(r + 0.5));
        return -$rtoi($floor(-r + 0.5));
    endfunction

    function automatic int sin_ref(input int p);
        return round_away(2047.0 * $sin(2.0 * PI * real'(p) / 4096.0));
    endfunction

    function automatic int isqrt_ref(input int x);
        int q;
        q = $rtoi($floor($sqrt(real'(x))));
        while (q * q > x) q--;
        while ((q + 1) * (q + 1) <= x) q++;
        return q;
    endfunction

    function automatic int rand_radicand();
        int k;
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 8388607));
            1: begin k = int'($urandom_range(0, 2896)); return k * k; end
            2: begin k = int'($urandom_range(1, 2896)); return k * k - 1; end
            default: return int'($urandom_range(0, 1023));
        endcase
    endfunction

    task automatic drive(input int p, input int x, input int exp_s, input int exp_q);
        exp_t e;
        @(negedge clk);
        bus.DAT_i  = 12'(p);
        bus.DATs_i = 23'(x);
        e.due = edge_cnt + 1;  e.val = exp_s; e.arg = p;
        sin_q.push_back(e);
        e.due = edge_cnt + 12; e.val = exp_q; e.arg = x;
        sq_q.push_back(e);
    endtask

    task automatic drive_rand();
        int p;
        int x;
        p = int'($urandom_range(0, 4095));
        x = rand_radicand();
        drive(p, x, sin_ref(p), isqrt_ref(x));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        edge_cnt++;
        if (!rst_n) begin
            chk("sin_in_reset", int'(bus.SIN_o), 0);
            chk("sqrt_in_reset", int'(bus.QQs_o), 0);
        end else begin
            if (sin_q.size() > 0 && sin_q[0].due == edge_cnt) begin
                e = sin_q.pop_front();
                obs[e.arg] = int'(bus.SIN_o);
                chk($sformatf("sin(p=%0d)", e.arg), int'(bus.SIN_o), e.val);
            end else if (sin_q.size() > 0 && sin_q[0].due < edge_cnt) begin
                e = sin_q.pop_front();
                chk("sin_missed_slot", e.due, edge_cnt);
            end
            if (sq_q.size() > 0 && sq_q[0].due == edge_cnt) begin
                e = sq_q.pop_front();
                chk($sformatf("sqrt(x=%0d)", e.arg), int'(bus.QQs_o), e.val);
            end else if (sq_q.size() > 0 && sq_q[0].due < edge_cnt) begin
                e = sq_q.pop_front();
                chk("sqrt_missed_slot", e.due, edge_cnt);
            end else if (edge_cnt - release_edge < 12) begin
                chk("sqrt_refill_zero", int'(bus.QQs_o), 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1);
    end

    int key_p [8] = '{0, 512, 1024, 1536, 2048, 2560, 3072, 4095};
    int key_s [8] = '{0, 1447, 2047, 1447, 0, -1447, -2047, -3};
    int bnd_x [9] = '{0, 1, 3, 4, 8385215, 8385216, 8386815, 8386816, 8388607};
    int bnd_q [9] = '{0, 1, 1, 2, 2895, 2895, 2895, 2896, 2896};

    initial begin
        int odd_bad;
        int mir_bad;
        int maxv;
        int minv;
        int px;

        for (int i = 0; i < 4096; i++) obs[i] = 9999;
        rst_n      = 1'b0;
        bus.DAT_i  = 12'd1024;
        bus.DATs_i = 23'd4000000;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b1;
        release_edge = edge_cnt;
        drive(1024, 4000000, 2047, 2000);

        for (int i = 0; i < 8; i++) begin
            px = rand_radicand();
            drive(key_p[i], px, key_s[i], isqrt_ref(px));
        end
        for (int i = 0; i < 9; i++) begin
            px = int'($urandom_range(0, 4095));
            drive(px, bnd_x[i], sin_ref(px), bnd_q[i]);
        end
        for (int p = 0; p < 4096; p++) begin
            px = rand_radicand();
            drive(p, px, sin_ref(p), isqrt_ref(px));
        end

        for (int i = 0; i < 20000; i++) begin
            if (i == 10000) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                sin_q.delete();
                sq_q.delete();
                #1;
                chk("sin_async_reset", int'(bus.SIN_o), 0);
                chk("sqrt_async_reset", int'(bus.QQs_o), 0);
                drive_rand();
                #2;
                rst_n = 1'b1;
                release_edge = edge_cnt;
            end else begin
                drive_rand();
            end
        end

        for (int i = 0; i < 20; i++) begin
            if (sin_q.size() == 0 && sq_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        chk("sin_queue_drained", sin_q.size(), 0);
        chk("sqrt_queue_drained", sq_q.size(), 0);

        odd_bad = 0;
        mir_bad = 0;
        maxv = -100000;
        minv = 100000;
        for (int p = 0; p < 2048; p++) if (obs[p + 2048] != -obs[p]) odd_bad++;
        for (int k = 1; k < 1024; k++) if (obs[1024 + k] != obs[1024 - k]) mir_bad++;
        for (int p = 0; p < 4096; p++) begin
            if (obs[p] > maxv) maxv = obs[p];
            if (obs[p] < minv) minv = obs[p];
        end
        chk("sin_odd_symmetry_violations", odd_bad, 0);
        chk("sin_mirror_symmetry_violations", mir_bad, 0);
        chk("sin_max", maxv, 2047);
        chk("sin_min", minv, -2047);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
